// File: rtl/karatsuba_arbiter.sv
// karatsuba_arbiter: round-robin arbiter/sequencer sharing one multiplier among NREQ requesters.
// Optional watchdog with error response: define KARA_ARB_TIMEOUT_EN.  Rev 1.0
`default_nettype none

module karatsuba_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 16,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [2*W-1:0]      rsp_product,
    output logic                mul_start,
    output logic [W-1:0]        mul_a,
    output logic [W-1:0]        mul_b,
    input  logic [2*W-1:0]      mul_product,
    input  logic                mul_done,
`ifdef KARA_ARB_TIMEOUT_EN
    output logic                rsp_err,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_cur_id;

    logic             w_gnt_vld;
    logic [IDW-1:0]   w_gnt_id;
    logic [IDW-1:0]   w_next_ptr;
    logic [W-1:0]     w_sel_a;
    logic [W-1:0]     w_sel_b;

`ifdef KARA_ARB_TIMEOUT_EN
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WDW-1:0]   r_wd_cnt;
`endif

    // Scan from the highest offset down so the lowest offset from r_rr_ptr wins.
    always_comb begin
        int v_idx;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_idx = (int'(r_rr_ptr) + k) % NREQ;
            if (req_valid[v_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = IDW'(v_idx);
            end
        end
    end

    assign w_next_ptr = IDW'((int'(w_gnt_id) + 1) % NREQ);
    assign w_sel_a    = req_a[int'(w_gnt_id)*W +: W];
    assign w_sel_b    = req_b[int'(w_gnt_id)*W +: W];

    always_comb begin
        req_ready = '0;
        if (r_state == S_IDLE && w_gnt_vld) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_cur_id    <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            busy        <= 1'b0;
`ifdef KARA_ARB_TIMEOUT_EN
            rsp_err     <= 1'b0;
            r_wd_cnt    <= '0;
`endif
        end else begin
            mul_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        mul_a     <= w_sel_a;
                        mul_b     <= w_sel_b;
                        r_cur_id  <= w_gnt_id;
                        r_rr_ptr  <= w_next_ptr;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef KARA_ARB_TIMEOUT_EN
                    r_wd_cnt <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        rsp_product <= mul_product;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= r_cur_id;
`ifdef KARA_ARB_TIMEOUT_EN
                        rsp_err     <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef KARA_ARB_TIMEOUT_EN
                    // Counter value equals WAIT cycles already spent, so TIMEOUT-1 is the last one.
                    else if (r_wd_cnt == WDW'(TIMEOUT - 1)) begin
                        rsp_product <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= r_cur_id;
                        rsp_err     <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_karatsuba_arbiter.sv
// tb_karatsuba_arbiter: directed bench with a transaction-level reference model and a model multiplier.
`default_nettype none

module tb_karatsuba_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_a;
    logic [N*W-1:0]    req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [2*W-1:0]    rsp_product;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_product = '0;
    logic              mul_done = 1'b0;
    logic              busy;
`ifdef KARA_ARB_TIMEOUT_EN
    logic              rsp_err;
`endif

    karatsuba_arbiter #(.NREQ(N), .W(W), .IDW(2), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_product(rsp_product),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_product(mul_product), .mul_done(mul_done),
`ifdef KARA_ARB_TIMEOUT_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model multiplier: result mm_lat cycles after start (0 = done on the first WAIT cycle).
    int          mm_lat   = 2;
    bit          mm_stall = 1'b0;
    int          mm_cnt   = 0;
    logic [W-1:0] mm_pa = '0, mm_pb = '0;

    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (rst) begin
            mm_cnt <= 0;
        end else if (mul_start) begin
            if (!mm_stall && mm_lat == 0) begin
                mul_done    <= 1'b1;
                mul_product <= 32'(mul_a) * 32'(mul_b);
            end else begin
                mm_cnt <= mm_lat;
                mm_pa  <= mul_a;
                mm_pb  <= mul_b;
            end
        end else if (mm_cnt != 0) begin
            mm_cnt <= mm_cnt - 1;
            if (mm_cnt == 1 && !mm_stall) begin
                mul_done    <= 1'b1;
                mul_product <= 32'(mm_pa) * 32'(mm_pb);
            end
        end
    end

    // Reference model: 0 idle, 1 start cycle, 2 awaiting result, 3 responding.
    int           m_st = 0;
    bit           m_known = 1'b0;
    int           m_ptr = 0;
    int           m_id = 0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [31:0]  m_prod = '0;
    bit           m_err = 1'b0;
    int           m_wcnt = 0;
    int           gnt_q[$];
    int           rid_q[$];
    logic [31:0]  rprod_q[$];
    bit           rerr_q[$];

    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        int g;
        if (m_known) begin
            exp_rdy = '0;
            g = -1;
            if (m_st == 0) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready", req_ready, exp_rdy);
            chk("busy", busy, m_st != 0);
            chk("mul_start", mul_start, m_st == 1);
            chk("rsp_valid", rsp_valid, m_st == 3);
            if (m_st == 1 || m_st == 2) begin
                chk("mul_a", mul_a, m_a);
                chk("mul_b", mul_b, m_b);
            end
            if (m_st == 3) begin
                chk("rsp_id", rsp_id, m_id);
                chk("rsp_product", rsp_product, m_prod);
`ifdef KARA_ARB_TIMEOUT_EN
                chk("rsp_err", rsp_err, m_err);
`endif
            end
            case (m_st)
                0: if (g >= 0) begin
                    m_a   = req_a[g*W +: W];
                    m_b   = req_b[g*W +: W];
                    m_id  = g;
                    m_ptr = (g + 1) % N;
                    gnt_q.push_back(g);
                    m_st  = 1;
                end
                1: begin
                    m_wcnt = 0;
                    m_st   = 2;
                end
                2: if (mul_done) begin
                    m_prod = 32'(m_a) * 32'(m_b);
                    m_err  = 1'b0;
                    m_st   = 3;
                end else begin
                    m_wcnt++;
`ifdef KARA_ARB_TIMEOUT_EN
                    if (m_wcnt >= TO) begin
                        m_prod = '0;
                        m_err  = 1'b1;
                        m_st   = 3;
                    end
`endif
                end
                default: if (rsp_ready) begin
                    rid_q.push_back(m_id);
                    rprod_q.push_back(m_prod);
                    rerr_q.push_back(m_err);
                    m_st = 0;
                end
            endcase
        end
        if (rst) begin
            m_st    = 0;
            m_ptr   = 0;
            m_known = 1'b1;
        end
    end

    logic [N-1:0] keep = '0;

    // One clock: accepted requests drop valid unless they are held continuously.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~(acc & ~keep);
    endtask

    task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_valid[id]    = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        gnt_q.delete();
        rid_q.delete();
        rprod_q.delete();
        rerr_q.delete();
    endtask

    task automatic wait_rsp(input int n);
        int b = 0;
        while (rid_q.size() < n && b < 1000) begin
            step();
            b++;
        end
        chk("wait_rsp_count", rid_q.size(), n);
    endtask

    task automatic wait_state(input int st);
        int b = 0;
        while (m_st != st && b < 1000) begin
            step();
            b++;
        end
        chk("wait_state", m_st, st);
    endtask

    initial begin
        int n0;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_product", rsp_product, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        chk("rst_busy", busy, 0);

        // Single request 3*4
        mm_lat = 2;
        drive(0, 16'd3, 16'd4);
        n0 = 0;
        while (gnt_q.size() < 1 && n0 < 20) begin step(); n0++; end
        chk("t1_start_pulse", mul_start, 1);
        chk("t1_mul_a", mul_a, 3);
        wait_rsp(1);
        chk("t1_id", rid_q[0], 0);
        chk("t1_product", rprod_q[0], 12);

        // Four simultaneous requesters, served in ID order
        do_reset();
        mm_lat = 0;
        drive(0, 16'd255, 16'd255);
        drive(1, 16'd123, 16'd456);
        drive(2, 16'd1023, 16'd1023);
        drive(3, 16'd30000, 16'd2);
        wait_rsp(4);
        chk("t2_id0", rid_q[0], 0);
        chk("t2_id1", rid_q[1], 1);
        chk("t2_id2", rid_q[2], 2);
        chk("t2_id3", rid_q[3], 3);
        chk("t2_p0", rprod_q[0], 65025);
        chk("t2_p1", rprod_q[1], 56088);
        chk("t2_p2", rprod_q[2], 1046529);
        chk("t2_p3", rprod_q[3], 60000);

        // Requesters 1 and 3 held valid: strict alternation
        do_reset();
        mm_lat = 1;
        keep = 4'b1010;
        drive(1, 16'd1, 16'd65535);
        drive(3, 16'd2, 16'd3);
        n0 = 0;
        while (gnt_q.size() < 6 && n0 < 200) begin step(); n0++; end
        keep = '0;
        req_valid = '0;
        wait_rsp(6);
        for (int i = 0; i < 6; i++) chk("t3_grant_order", gnt_q[i], (i % 2 == 0) ? 1 : 3);
        chk("t3_p_req1", rprod_q[0], 65535);
        chk("t3_p_req3", rprod_q[1], 6);

        // Back-pressure: 10 cycles held in RESP, a competing request must wait
        rsp_ready = 1'b0;
        drive(2, 16'd7, 16'd9);
        wait_state(3);
        drive(0, 16'd5, 16'd5);
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_id", rsp_id, 2);
            chk("bp_rsp_product", rsp_product, 63);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_mul_start", mul_start, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_next_grant", req_ready, 4'b0001);
        wait_rsp(8);
        chk("bp_after_id", rid_q[7], 0);
        chk("bp_after_p", rprod_q[7], 25);

        // Reset while waiting on the multiplier abandons the request
        mm_stall = 1'b1;
        drive(1, 16'd5, 16'd6);
        wait_state(2);
        step();
        step();
        n0 = rid_q.size();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_busy", busy, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_mul_ab", {mul_a, mul_b}, 0);
        chk("mr_req_ready", req_ready, 0);
        chk("mr_rsp_product", rsp_product, 0);
        repeat (4) step();
        chk("mr_no_rsp", rid_q.size(), n0);
        mm_stall = 1'b0;
        drive(2, 16'd0, 16'd123);
        wait_rsp(n0 + 1);
        chk("mr_new_id", rid_q[n0], 2);
        chk("mr_new_p", rprod_q[n0], 0);

`ifdef KARA_ARB_TIMEOUT_EN
        // Watchdog: response with error exactly TO cycles after entering WAIT
        do_reset();
        mm_stall = 1'b1;
        drive(0, 16'd9, 16'd9);
        wait_state(2);
        n0 = 0;
        while (!rsp_valid && n0 < 200) begin step(); n0++; end
        chk("to_cycles", n0, TO);
        chk("to_err", rsp_err, 1);
        chk("to_product", rsp_product, 0);
        wait_rsp(1);
        mm_stall = 1'b0;
        drive(3, 16'd10, 16'd11);
        wait_rsp(2);
        chk("to_normal_err", rerr_q[1], 0);
        chk("to_normal_p", rprod_q[1], 110);
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "global timeout");
    end

endmodule

`default_nettype wire
